// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Single-digit BCD (decade) up/down counter with synchronous parallel load,
// two cascade enables and a ripple carry/borrow output. Its behaviour matches
// the 74x160/74x190 family. QA..QD feed a BCD-to-decimal decoder, with QA as
// the LSB. To build a multi-digit counter, drive each stage's ENT from the
// RCO of the stage below it and share ENP across all stages.
//
// Parameters
//   RESET_VALUE : 4-bit value (0..9) forced into the count while CLR_N is low
//
// Ports
//   CLK            in   counter clock, rising edge
//   CLR_N          in   asynchronous active-low clear to RESET_VALUE
//   LOAD_N         in   synchronous active-low parallel load
//   ENP            in   parallel count enable (does not gate RCO)
//   ENT            in   trickle count enable (gates RCO)
//   DN             in   direction: 0 = up, 1 = down
//   DA..DD         in   parallel load data, DA is the LSB
//   QA..QD         out  registered count, QA is the LSB
//   MAXMIN         out  terminal count: Q==9 counting up, Q==0 counting down
//   RCO            out  ripple carry/borrow, ENT & MAXMIN
//
// Operation priority, highest first: clear, load, count (ENP & ENT), hold.
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter logic [3:0] RESET_VALUE = 4'd0
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic LOAD_N,
    input  logic ENP,
    input  logic ENT,
    input  logic DN,
    input  logic DA,
    input  logic DB,
    input  logic DC,
    input  logic DD,
    output logic QA,
    output logic QB,
    output logic QC,
    output logic QD,
    output logic MAXMIN,
    output logic RCO
);

    // The count register is the only state in this block.
    logic [3:0] q;
    logic [3:0] load_data;
    logic [3:0] up_next;
    logic [3:0] down_next;
    logic       count_en;

    assign load_data = {DD, DC, DB, DA};
    assign count_en  = ENP & ENT;

    // Modulo-10 successors. Codes 10..15 can only appear through a load. The
    // next count edge sends them back into range: 0 when counting up, 9 when
    // counting down.
    always_comb begin
        up_next   = 4'd0;
        down_next = 4'd9;
        if (q < 4'd9) begin
            up_next = q + 4'd1;
        end
        if ((q != 4'd0) && (q <= 4'd9)) begin
            down_next = q - 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            q <= RESET_VALUE;
        end else if (!LOAD_N) begin
            q <= load_data;
        end else if (count_en) begin
            q <= DN ? down_next : up_next;
        end
    end

    // Terminal count follows DN combinationally. A change of direction
    // therefore shows up on MAXMIN/RCO at once, and on Q at the next count
    // edge. Out-of-range codes never compare equal to 0 or 9, so MAXMIN stays
    // low for them.
    always_comb begin
        MAXMIN = DN ? (q == 4'd0) : (q == 4'd9);
        RCO    = ENT & MAXMIN;
    end

    assign QA = q[0];
    assign QB = q[1];
    assign QC = q[2];
    assign QD = q[3];

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Drives a standalone counter and a two-digit cascade (tens ENT driven from
// the units RCO). The driver pushes hand-computed expectations into exp_q and
// signals that outputs are ready. The monitor pops each entry and compares it.
//
// Entry layout: [12] selects the cascade pair. [11:6] holds {rco,maxmin,q} of
// the tens digit. [5:0] holds {rco,maxmin,q} of the single counter or of the
// units digit.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

    localparam int W = 13;

    // clock / reset
    logic clk;
    logic clr_n;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // single counter
    logic load_n, enp, ent, dn;
    logic [3:0] d;
    logic qa, qb, qc, qd, maxmin, rco;
    logic [3:0] q;

    assign q = {qd, qc, qb, qa};

    bcd_updown_counter #(.RESET_VALUE(4'd0)) dut (
        .CLK(clk), .CLR_N(clr_n), .LOAD_N(load_n), .ENP(enp), .ENT(ent), .DN(dn),
        .DA(d[0]), .DB(d[1]), .DC(d[2]), .DD(d[3]),
        .QA(qa), .QB(qb), .QC(qc), .QD(qd), .MAXMIN(maxmin), .RCO(rco)
    );

    // two-digit cascade
    logic c_enp;
    logic [3:0] u_q, t_q;
    logic u_mm, u_rco, t_mm, t_rco;

    bcd_updown_counter #(.RESET_VALUE(4'd0)) units (
        .CLK(clk), .CLR_N(clr_n), .LOAD_N(1'b1), .ENP(c_enp), .ENT(1'b1), .DN(1'b0),
        .DA(1'b0), .DB(1'b0), .DC(1'b0), .DD(1'b0),
        .QA(u_q[0]), .QB(u_q[1]), .QC(u_q[2]), .QD(u_q[3]), .MAXMIN(u_mm), .RCO(u_rco)
    );

    bcd_updown_counter #(.RESET_VALUE(4'd0)) tens (
        .CLK(clk), .CLR_N(clr_n), .LOAD_N(1'b1), .ENP(c_enp), .ENT(u_rco), .DN(1'b0),
        .DA(1'b0), .DB(1'b0), .DC(1'b0), .DD(1'b0),
        .QA(t_q[0]), .QB(t_q[1]), .QC(t_q[2]), .QD(t_q[3]), .MAXMIN(t_mm), .RCO(t_rco)
    );

    // scoreboard state
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    event         pushed;
    int           checks = 0;
    int           errors = 0;

    // BCD-to-decimal decoder model: one-hot for 0..9, no output for 10..15.
    function automatic logic [9:0] dec(input logic [3:0] v);
        logic [9:0] r;
        r = '0;
        if (v < 4'd10) r[v] = 1'b1;
        return r;
    endfunction

    // driver tasks
    task automatic push_exp(input string name, input logic [W-1:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
        -> pushed;
        #2;
    endtask

    task automatic expect_single(input string name, input logic r, input logic m,
                                 input logic [3:0] v);
        push_exp(name, {1'b0, 6'b0, r, m, v});
    endtask

    // One rising edge with the inputs already applied. The check runs just
    // after the edge, and the task returns shortly after the falling edge.
    task automatic edge_check(input string name, input logic r, input logic m,
                              input logic [3:0] v);
        @(posedge clk);
        #1;
        expect_single(name, r, m, v);
        @(negedge clk);
        #1;
    endtask

    // Check with no clock edge involved (asynchronous or combinational).
    task automatic comb_check(input string name, input logic r, input logic m,
                              input logic [3:0] v);
        #1;
        expect_single(name, r, m, v);
    endtask

    // monitor
    initial begin : monitor
        logic [W-1:0] e;
        logic [11:0]  act;
        string        nm;
        forever begin
            @(pushed);
            #1;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e[12]) act = {t_rco, t_mm, t_q, u_rco, u_mm, u_q};
                else       act = {6'b0, rco, maxmin, q};
                checks++;
                if (act !== e[11:0]) begin
                    errors++;
                    $display("FAIL %s: got {rco,mm,q}=%b need %b", nm, act, e[11:0]);
                end
                if (e[12]) begin
                    checks++;
                    if ($countones(dec(u_q)) != 1 || $countones(dec(t_q)) != 1) begin
                        errors++;
                        $display("FAIL %s decode: got units=%0d tens=%0d need one-hot each",
                                 nm, u_q, t_q);
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "timeout");
    end

    // stimulus
    initial begin
        clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; dn = 1'b0; d = 4'd0;
        c_enp = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // reset state; MAXMIN/RCO follow DN and ENT while held in reset
        ent = 1'b1;
        comb_check("reset_up", 1'b0, 1'b0, 4'd0);
        dn = 1'b1;
        comb_check("reset_dn", 1'b1, 1'b1, 4'd0);
        @(negedge clk);
        #1;
        dn = 1'b0;
        clr_n = 1'b1;

        // asynchronous clear while counting
        load_n = 1'b0; d = 4'd5;
        edge_check("load5", 1'b0, 1'b0, 4'd5);
        load_n = 1'b1; enp = 1'b1;
        edge_check("count6", 1'b0, 1'b0, 4'd6);
        clr_n = 1'b0;
        comb_check("async_clr", 1'b0, 1'b0, 4'd0);
        clr_n = 1'b1;
        edge_check("post_clr1", 1'b0, 1'b0, 4'd1);
        edge_check("post_clr2", 1'b0, 1'b0, 4'd2);
        edge_check("post_clr3", 1'b0, 1'b0, 4'd3);

        // up wrap, RCO gated by ENT
        enp = 1'b0; load_n = 1'b0; d = 4'd7;
        edge_check("load7", 1'b0, 1'b0, 4'd7);
        load_n = 1'b1; enp = 1'b1;
        edge_check("up8", 1'b0, 1'b0, 4'd8);
        edge_check("up9", 1'b1, 1'b1, 4'd9);
        ent = 1'b0;
        comb_check("rco_ent0", 1'b0, 1'b1, 4'd9);
        ent = 1'b1;
        comb_check("rco_ent1", 1'b1, 1'b1, 4'd9);
        edge_check("up_wrap0", 1'b0, 1'b0, 4'd0);

        // down wrap
        enp = 1'b0; load_n = 1'b0; d = 4'd2;
        edge_check("load2", 1'b0, 1'b0, 4'd2);
        load_n = 1'b1; enp = 1'b1; dn = 1'b1;
        edge_check("dn1", 1'b0, 1'b0, 4'd1);
        edge_check("dn0", 1'b1, 1'b1, 4'd0);
        edge_check("dn_wrap9", 1'b0, 1'b0, 4'd9);
        edge_check("dn8", 1'b0, 1'b0, 4'd8);

        // load beats count; ENP low holds
        dn = 1'b0; load_n = 1'b0; d = 4'd5; enp = 1'b1; ent = 1'b1;
        edge_check("load_wins", 1'b0, 1'b0, 4'd5);
        load_n = 1'b1; enp = 1'b0;
        for (int i = 0; i < 4; i++) edge_check("hold_enp0", 1'b0, 1'b0, 4'd5);

        // invalid codes recover on the next count
        load_n = 1'b0; d = 4'd12;
        edge_check("load12", 1'b0, 1'b0, 4'd12);
        dn = 1'b1;
        comb_check("mm_12_dn", 1'b0, 1'b0, 4'd12);
        dn = 1'b0; load_n = 1'b1; enp = 1'b1;
        edge_check("rec12_up", 1'b0, 1'b0, 4'd0);
        enp = 1'b0; load_n = 1'b0; d = 4'd15;
        edge_check("load15", 1'b0, 1'b0, 4'd15);
        load_n = 1'b1; dn = 1'b1; enp = 1'b1;
        edge_check("rec15_dn", 1'b0, 1'b0, 4'd9);
        enp = 1'b0;

        // two-digit cascade from 00, 100 consecutive up edges
        c_enp = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            int un, tn;
            un = i % 10;
            tn = (i / 10) % 10;
            @(posedge clk);
            #1;
            push_exp($sformatf("cascade_%0d", i),
                     {1'b1, (un == 9 && tn == 9), (tn == 9), 4'(tn),
                            (un == 9), (un == 9), 4'(un)});
        end
        c_enp = 1'b0;

        @(negedge clk);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
